// File: rtl/vga_pkg.sv
// Shared definitions for the VGA drawing blocks.
//   SCREEN_W_DEFAULT / SCREEN_H_DEFAULT : default frame size in pixels
//   X_W / Y_W / COLOUR_W                : adapter coordinate and colour widths
//   COORD_W / CRIT_W                    : signed working widths for the circle walker
//   circle_state_t                      : circle rasteriser FSM states
package vga_pkg;

    localparam int unsigned SCREEN_W_DEFAULT = 160;
    localparam int unsigned SCREEN_H_DEFAULT = 120;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CRIT_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLOT = 2'd1,
        DONE = 2'd2
    } circle_state_t;

    // Sign-extend a working coordinate to the decision-variable width.
    function automatic logic signed [CRIT_W-1:0] to_crit(input logic signed [COORD_W-1:0] v);
        return $signed({{(CRIT_W - COORD_W){v[COORD_W-1]}}, v});
    endfunction

endpackage

// File: rtl/circle_octant_sel.sv
// Combinational octant mirror for the circle rasteriser.
//   oct       : which of the eight mirrored points to produce (0..7)
//   cx, cy    : circle centre, signed working width
//   ox, oy    : current octant offsets, signed working width
//   px, py    : selected point, signed working width
//   on_screen : point lies inside 0 <= x < SCREEN_W, 0 <= y < SCREEN_H
module circle_octant_sel
    import vga_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEFAULT,
    parameter int unsigned SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic [2:0]                oct,
    input  logic signed [COORD_W-1:0] cx,
    input  logic signed [COORD_W-1:0] cy,
    input  logic signed [COORD_W-1:0] ox,
    input  logic signed [COORD_W-1:0] oy,
    output logic signed [COORD_W-1:0] px,
    output logic signed [COORD_W-1:0] py,
    output logic                      on_screen
);

    localparam logic signed [COORD_W-1:0] XLIM = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] YLIM = COORD_W'(SCREEN_H);

    always_comb begin
        px = cx;
        py = cy;
        case (oct)
            3'd0: begin px = cx + ox; py = cy + oy; end
            3'd1: begin px = cx + oy; py = cy + ox; end
            3'd2: begin px = cx - ox; py = cy + oy; end
            3'd3: begin px = cx - oy; py = cy + ox; end
            3'd4: begin px = cx - ox; py = cy - oy; end
            3'd5: begin px = cx - oy; py = cy - ox; end
            3'd6: begin px = cx + ox; py = cy - oy; end
            default: begin px = cx + oy; py = cy - ox; end
        endcase
    end

    assign on_screen = (px >= 0) && (px < XLIM) && (py >= 0) && (py < YLIM);

endmodule

// File: rtl/circle.sv
// Midpoint circle rasteriser feeding the VGA adapter.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : level request to draw; must drop before the next draw
//   centre_x/centre_y    : circle centre
//   radius, colour       : circle radius and pixel colour
//   done                 : drawing finished
//   vga_x/vga_y          : registered pixel coordinate to the adapter
//   vga_colour, vga_plot : registered colour and write strobe to the adapter
module circle
    import vga_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEFAULT,
    parameter int unsigned SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [X_W-1:0]      radius,
    input  logic [COLOUR_W-1:0] colour,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    circle_state_t              state_q, state_d;
    logic [X_W-1:0]             cx_q, cx_d;
    logic [Y_W-1:0]             cy_q, cy_d;
    logic [COLOUR_W-1:0]        colour_q, colour_d;
    logic signed [COORD_W-1:0]  ox_q, ox_d, oy_q, oy_d;
    logic signed [CRIT_W-1:0]   crit_q, crit_d;
    logic [2:0]                 oct_q, oct_d;

    logic                       done_q, done_d, plot_q, plot_d;
    logic [X_W-1:0]             vga_x_q, vga_x_d;
    logic [Y_W-1:0]             vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]        vga_colour_q, vga_colour_d;

    logic signed [COORD_W-1:0]  px, py, oy_inc, ox_dec;
    logic                       on_screen;
    logic                       unused_bits;

    circle_octant_sel #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_octant_sel (
        .oct       (oct_q),
        .cx        ($signed({{(COORD_W - X_W){1'b0}}, cx_q})),
        .cy        ($signed({{(COORD_W - Y_W){1'b0}}, cy_q})),
        .ox        (ox_q),
        .oy        (oy_q),
        .px        (px),
        .py        (py),
        .on_screen (on_screen)
    );

    // High coordinate bits only matter for clipping, which on_screen already covers.
    assign unused_bits = ^{px[COORD_W-1:X_W], py[COORD_W-1:Y_W]};

    assign oy_inc = oy_q + 10'sd1;
    assign ox_dec = ox_q - 10'sd1;

    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        colour_d     = colour_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        crit_d       = crit_q;
        oct_d        = oct_q;
        // done trails the DONE state by one edge so it rises after the last point.
        done_d       = (state_q == DONE);
        plot_d       = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d     = centre_x;
                    cy_d     = centre_y;
                    colour_d = colour;
                    ox_d     = $signed({{(COORD_W - X_W){1'b0}}, radius});
                    oy_d     = '0;
                    crit_d   = 12'sd1 - $signed({{(CRIT_W - X_W){1'b0}}, radius});
                    oct_d    = 3'd0;
                    state_d  = PLOT;
                end
            end
            PLOT: begin
                plot_d       = on_screen;
                vga_x_d      = px[X_W-1:0];
                vga_y_d      = py[Y_W-1:0];
                vga_colour_d = colour_q;
                oct_d        = oct_q + 3'd1;
                if (oct_q == 3'd7) begin
                    oy_d = oy_inc;
                    if (crit_q <= 0) begin
                        crit_d = crit_q + (to_crit(oy_inc) <<< 1) + 12'sd1;
                        if (oy_inc > ox_q) state_d = DONE;
                    end else begin
                        ox_d   = ox_dec;
                        crit_d = crit_q + ((to_crit(oy_inc) - to_crit(ox_dec)) <<< 1) + 12'sd1;
                        if (oy_inc > ox_dec) state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cx_q         <= '0;
            cy_q         <= '0;
            colour_q     <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            crit_q       <= '0;
            oct_q        <= '0;
            done_q       <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            colour_q     <= colour_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            crit_q       <= crit_d;
            oct_q        <= oct_d;
            done_q       <= done_d;
            plot_q       <= plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_circle.sv
// Directed bench for the circle rasteriser: hand-computed small circles, a
// reference midpoint walk with framebuffer comparison, clipping, hold-start and reset abort.
module tb_circle;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    circle dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .colour     (colour),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_x[$];
    int exp_y[$];
    bit exp_p[$];
    int exp_iters;

    byte unsigned fb_dut[0:19199];
    byte unsigned fb_exp[0:19199];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_fb();
        for (int i = 0; i < 19200; i++) begin
            fb_dut[i] = 8'd0;
            fb_exp[i] = 8'd0;
        end
    endtask

    // Reference midpoint walk producing the expected point stream.
    task automatic build_model(input int cx, input int cy, input int r, input int col);
        int ox, oy, crit, px, py;
        bit on;
        exp_x.delete(); exp_y.delete(); exp_p.delete();
        exp_iters = 0;
        ox = r; oy = 0; crit = 1 - r;
        do begin
            for (int o = 0; o < 8; o++) begin
                case (o)
                    0: begin px = cx + ox; py = cy + oy; end
                    1: begin px = cx + oy; py = cy + ox; end
                    2: begin px = cx - ox; py = cy + oy; end
                    3: begin px = cx - oy; py = cy + ox; end
                    4: begin px = cx - ox; py = cy - oy; end
                    5: begin px = cx - oy; py = cy - ox; end
                    6: begin px = cx + ox; py = cy - oy; end
                    default: begin px = cx + oy; py = cy - ox; end
                endcase
                on = (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
                exp_x.push_back(px);
                exp_y.push_back(py);
                exp_p.push_back(on);
                if (on) fb_exp[py * 160 + px] = byte'(col);
            end
            exp_iters++;
            oy++;
            if (crit <= 0) begin
                crit += 2 * oy + 1;
            end else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    // Starts a draw and checks every output cycle against the expected stream.
    task automatic draw(input string name, input int cx, input int cy, input int r,
                        input int col, input bit hold, output int cycles);
        int idx;
        @(posedge clk); #1;
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r); colour = 3'(col);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        // Scribble on the inputs; a draw in progress must ignore them.
        centre_x = 8'd3; centre_y = 7'd100; radius = 8'd77; colour = 3'd7;
        cycles = 0;
        for (int k = 1; k <= 8 * exp_iters + 20; k++) begin
            @(posedge clk); #1;
            idx = k - 1;
            if (idx < exp_x.size()) begin
                check_eq($sformatf("%s plot[%0d]", name, idx), int'(vga_plot), int'(exp_p[idx]));
                if (exp_p[idx]) begin
                    check_eq($sformatf("%s x[%0d]", name, idx), int'(vga_x), exp_x[idx]);
                    check_eq($sformatf("%s y[%0d]", name, idx), int'(vga_y), exp_y[idx]);
                    check_eq($sformatf("%s colour[%0d]", name, idx), int'(vga_colour), col);
                end
            end else begin
                check_eq($sformatf("%s plot_after[%0d]", name, idx), int'(vga_plot), 0);
            end
            if (vga_plot && vga_y < 7'd120 && vga_x < 8'd160)
                fb_dut[int'(vga_y) * 160 + int'(vga_x)] = byte'(vga_colour);
            if (done) begin
                cycles = k;
                break;
            end
        end
        check_eq($sformatf("%s done_cycle", name), cycles, 1 + 8 * exp_iters);
    endtask

    int hx[16] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
    int hy[16] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};
    int cyc, cyc_clip, cyc_ref, mism;

    initial begin
        rst = 1'b1; start = 1'b0;
        centre_x = '0; centre_y = '0; radius = '0; colour = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset done", int'(done), 0);
        check_eq("reset plot", int'(vga_plot), 0);
        check_eq("reset x", int'(vga_x), 0);
        check_eq("reset y", int'(vga_y), 0);
        check_eq("reset colour", int'(vga_colour), 0);
        check_eq("reset state", int'(dut.state_q), int'(IDLE));
        rst = 1'b0;

        // r=1 at (80,60): hand-computed 16-point stream, done at cycle 17.
        exp_x.delete(); exp_y.delete(); exp_p.delete();
        for (int i = 0; i < 16; i++) begin
            exp_x.push_back(hx[i]);
            exp_y.push_back(hy[i]);
            exp_p.push_back(1'b1);
        end
        exp_iters = 2;
        draw("r1", 80, 60, 1, 2, 1'b0, cyc);
        check_eq("r1 cycles", cyc, 17);

        // r=40 at (80,60): stream plus full framebuffer comparison.
        clear_fb();
        build_model(80, 60, 40, 2);
        draw("r40", 80, 60, 40, 2, 1'b0, cyc);
        mism = 0;
        for (int i = 0; i < 19200; i++)
            if (fb_dut[i] != fb_exp[i]) mism++;
        check_eq("r40 framebuffer", mism, 0);

        // Clipped r=10 at the origin must take as long as an unclipped r=10.
        build_model(80, 60, 10, 5);
        draw("r10ref", 80, 60, 10, 5, 1'b0, cyc_ref);
        build_model(0, 0, 10, 5);
        draw("r10clip", 0, 0, 10, 5, 1'b0, cyc_clip);
        check_eq("clip cycles", cyc_clip, cyc_ref);

        // r=0 with start held: eight centre plots, then done sticks without replot.
        build_model(5, 5, 0, 4);
        draw("r0", 5, 5, 0, 4, 1'b1, cyc);
        check_eq("r0 cycles", cyc, 9);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("r0 hold done[%0d]", i), int'(done), 1);
            check_eq($sformatf("r0 hold plot[%0d]", i), int'(vga_plot), 0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("r0 back to idle", int'(dut.state_q), int'(IDLE));
        @(posedge clk); #1;
        check_eq("r0 done drops", int'(done), 0);

        // Reset at cycle 20 of an r=40 draw.
        @(posedge clk); #1;
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check_eq("pre-reset plot", int'(vga_plot), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort done", int'(done), 0);
        check_eq("abort plot", int'(vga_plot), 0);
        check_eq("abort x", int'(vga_x), 0);
        check_eq("abort y", int'(vga_y), 0);
        check_eq("abort colour", int'(vga_colour), 0);
        check_eq("abort state", int'(dut.state_q), int'(IDLE));
        rst = 1'b0;
        clear_fb();
        build_model(80, 60, 40, 6);
        draw("redraw", 80, 60, 40, 6, 1'b0, cyc);
        mism = 0;
        for (int i = 0; i < 19200; i++)
            if (fb_dut[i] != fb_exp[i]) mism++;
        check_eq("redraw framebuffer", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
